// File: rtl/pipelined_carry_select_add_sub.sv
// Pipelined N-bit two's-complement adder/subtractor built from SEG-bit carry-select
// segments spread over STAGES register stages, with valid/ready flow control and saturation.

module csel_seg #(
    parameter int SEG = 2
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);
    logic [SEG:0] s0, s1;

    // Both carry hypotheses are resolved up front; the incoming carry only drives the mux.
    assign s0   = {1'b0, a} + {1'b0, b};
    assign s1   = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    assign s    = cin ? s1[SEG-1:0] : s0[SEG-1:0];
    assign cout = cin ? s1[SEG] : s0[SEG];
endmodule

module pipelined_carry_select_add_sub #(
    parameter int N      = 16,
    parameter int SEG    = 2,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_subtract,
    input  logic         saturate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow_flag,
    output logic         negative,
    output logic         zero
);
    localparam int BPS = N / STAGES;
    localparam int SPS = BPS / SEG;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sum;
        logic         c;
        logic         sat;
    } stg_t;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] rdy;
    stg_t            in_stg;

    assign vld_pipe[0] = in_valid;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = vld_pipe[STAGES];

    // Subtract is folded in here as A + ~B with the +1 as the initial carry-in.
    assign in_stg = {a, b ^ {N{is_subtract}}, {N{1'b0}}, is_subtract, saturate};

    for (genvar k = 0; k < STAGES; k++) begin : stg
        stg_t           prv, nxt;
        logic           v_q;
        logic [SPS:0]   cc;
        logic [BPS-1:0] ssum;

        if (k == 0) begin : g_src
            assign prv = in_stg;
        end else begin : g_src
            assign prv = stg[k-1].g_reg.q;
        end

        assign cc[0] = prv.c;

        for (genvar j = 0; j < SPS; j++) begin : seg
            csel_seg #(.SEG(SEG)) u_seg (
                .a   (prv.a[k*BPS + j*SEG +: SEG]),
                .b   (prv.b[k*BPS + j*SEG +: SEG]),
                .cin (cc[j]),
                .s   (ssum[j*SEG +: SEG]),
                .cout(cc[j+1])
            );
        end

        always_comb begin
            nxt                  = prv;
            nxt.sum[k*BPS +: BPS] = ssum;
            nxt.c                = cc[SPS];
        end

        // A stage advances whenever it is empty or the stage after it moves.
        assign rdy[k]        = !v_q | rdy[k+1];
        assign vld_pipe[k+1] = v_q;

        always_ff @(posedge clk) begin
            if (!rst_n)      v_q <= 1'b0;
            else if (rdy[k]) v_q <= vld_pipe[k];
        end

        if (k < STAGES - 1) begin : g_reg
            stg_t q;
            always_ff @(posedge clk) begin
                if (!rst_n)      q <= '0;
                else if (rdy[k]) q <= nxt;
            end
        end
    end

    stg_t         fin;
    logic         c_msb, ovf, neg;
    logic [N-1:0] res;
    logic         unused_bits;

    assign fin   = stg[STAGES-1].nxt;
    assign c_msb = fin.a[N-1] ^ fin.b[N-1] ^ fin.sum[N-1];
    assign ovf   = c_msb ^ fin.c;
    assign neg   = ovf ^ fin.sum[N-1];

    // Operand bits below the MSB have no consumer once the last segment is summed.
    assign unused_bits = ^{fin.a[N-2:0], fin.b[N-2:0]};

    always_comb begin
        res = fin.sum;
        if (fin.sat && ovf) res = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result        <= '0;
            carry         <= 1'b0;
            overflow_flag <= 1'b0;
            negative      <= 1'b0;
            zero          <= 1'b0;
        end else if (rdy[STAGES-1]) begin
            result        <= res;
            carry         <= fin.c;
            overflow_flag <= ovf;
            negative      <= neg;
            zero          <= (res == '0);
        end
    end
endmodule
